// File: rtl/output_buffer_fsm_if.sv
// ---------------------------------------------------------------------------
// output_buffer_fsm_if
//   Bundles the two streams that pass through the output buffer:
//     - pixel stream from the convolution controller:
//         in_valid, in_data (signed ACC_WIDTH), in_x, in_y, in_ch, and stall
//         back toward the controller
//     - drain stream toward the external consumer:
//         out_valid, out_ready, out_data (signed OUT_WIDTH), out_x, out_y, out_ch
//   Modports:
//     master : the environment (controller + consumer) side
//     slave  : the output buffer itself
// ---------------------------------------------------------------------------
interface output_buffer_fsm_if #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16
);
  logic                        in_valid;
  logic signed [ACC_WIDTH-1:0] in_data;
  logic [31:0]                 in_x;
  logic [31:0]                 in_y;
  logic [31:0]                 in_ch;
  logic                        stall;

  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [31:0]                 out_x;
  logic [31:0]                 out_y;
  logic [31:0]                 out_ch;

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  stall, out_valid, out_data, out_x, out_y, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output stall, out_valid, out_data, out_x, out_y, out_ch
  );
endinterface

// File: rtl/output_buffer_fsm.sv
// ---------------------------------------------------------------------------
// output_buffer_fsm
//   Output stage behind the convolution controller / MAC datapath. Captures
//   each finished pixel (accumulator + x/y/channel tags), saturates it to
//   OUT_WIDTH, buffers it in a DEPTH-entry FIFO and drains it over a
//   valid/ready handshake. Raises stall when the FIFO is nearly full and
//   done once FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS outputs
//   have been delivered.
//
// Ports:
//   clk        rising-edge clock
//   arst_n_in  synchronous active-low reset
//   start      arms the block for a new layer (IDLE->RUN, DONE->RUN)
//   bus        output_buffer_fsm_if.slave: in_valid/in_data/in_x/in_y/in_ch,
//              stall, out_valid/out_ready/out_data/out_x/out_y/out_ch
//   done       all outputs of the layer delivered (held in DONE)
//   overflow   sticky: a push arrived while full with no pop and was dropped
//
// Optional feature: define OUTBUF_RELU_EN to clamp negative accumulator
// values to 0 before saturation.
// ---------------------------------------------------------------------------
module output_buffer_fsm #(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int ACC_WIDTH          = 32,
  parameter int OUT_WIDTH          = 16,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                clk,
  input  logic                arst_n_in,
  input  logic                start,
  output_buffer_fsm_if.slave  bus,
  output logic                done,
  output logic                overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = OUT_WIDTH + 96;

  localparam logic [31:0]      TOTAL      =
    32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_CNT = CNT_W'(ALMOST_FULL_MARGIN);

  // Saturation bounds expressed at accumulator width so the compare is
  // done on the full signed value.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [OUT_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH-1:0] value
  );
    logic signed [ACC_WIDTH-1:0] v;
    v = value;
`ifdef OUTBUF_RELU_EN
    if (v[ACC_WIDTH-1]) v = '0;
`endif
    if (v > SAT_MAX)      saturate = SAT_MAX[OUT_WIDTH-1:0];
    else if (v < SAT_MIN) saturate = SAT_MIN[OUT_WIDTH-1:0];
    else                  saturate = v[OUT_WIDTH-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [31:0]          pop_cnt_reg, pop_cnt_next;
  logic                 overflow_reg;
  logic                 out_valid_reg;
  logic [ENTRY_W-1:0]   head_reg, head_next;
  logic [ENTRY_W-1:0]   mem [DEPTH];

  logic                 run;
  logic                 push_req;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 ovf_clear;
  logic [ENTRY_W-1:0]   entry_in;

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  assign run      = (state_reg == RUN);
  assign push_req = bus.in_valid && run;
  assign full     = (count_reg == DEPTH_CNT);
  // Pops are allowed in any state so leftovers can always be drained.
  assign pop      = out_valid_reg && bus.out_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign entry_in = {saturate(bus.in_data), bus.in_x, bus.in_y, bus.in_ch};

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    if (push && !pop)      count_next = count_reg + CNT_W'(1);
    else if (!push && pop) count_next = count_reg - CNT_W'(1);
  end

  // Next head entry. If the slot being written this edge is the one that
  // becomes the head (FIFO empty, or draining down to the new entry), bypass
  // the array so the entry is visible one cycle after the push.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (push && (wr_ptr_reg == rd_ptr_next)) head_next = entry_in;
  end

  // -------------------------------------------------------------------------
  // Layer FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!arst_n_in) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    pop_cnt_next = pop_cnt_reg;
    ovf_clear    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (pop) begin
          pop_cnt_next = pop_cnt_reg + 32'd1;
          if (pop_cnt_reg == TOTAL - 32'd1) state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          pop_cnt_next = '0;
          ovf_clear    = 1'b1;
          state_next   = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage array (no reset so it maps onto RAM)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= entry_in;
  end

  // -------------------------------------------------------------------------
  // Pointers, counters, head register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      pop_cnt_reg   <= '0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      head_reg      <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      pop_cnt_reg   <= pop_cnt_next;
      out_valid_reg <= (count_next != '0);
      if (ovf_clear) overflow_reg <= 1'b0;
      else if (drop) overflow_reg <= 1'b1;
      // Only refresh when a real entry will be at the head; keeps out_* at
      // their reset value until the first push and stable when empty.
      if (count_next != '0) head_reg <= head_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = head_reg[ENTRY_W-1 -: OUT_WIDTH];
  assign bus.out_x     = head_reg[95:64];
  assign bus.out_y     = head_reg[63:32];
  assign bus.out_ch    = head_reg[31:0];
  assign bus.stall     = run && ((DEPTH_CNT - count_reg) <= MARGIN_CNT);
  assign done          = (state_reg == DONE);
  assign overflow      = overflow_reg;

endmodule
